// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for rename.
// Hands out pd_new from the head, reclaims retired tags at the tail, and
// keeps one checkpoint of the head pointer so a mispredict returns every
// speculatively allocated tag in a single cycle.
// Optional feature macro: FREE_LIST_BYPASS_EN (free-to-alloc bypass at empty).
module free_list #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 128,
    parameter int DEPTH    = NUM_PHYS - NUM_ARCH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_req,
    output logic                         alloc_gnt,
    output logic [$clog2(NUM_PHYS)-1:0]  pd_new,
    output logic                         empty,
    input  logic                         free_en,
    input  logic [$clog2(NUM_PHYS)-1:0]  free_pd,
    input  logic                         ckpt_take,
    input  logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow_err
);

    localparam int TAG_W = $clog2(NUM_PHYS);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Storage and architectural state
    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] ckpt_head;
    logic [CNT_W-1:0] alloc_since_ckpt;

    // Decoded per-cycle events
    logic free_ok;
    logic free_drop;
    logic bypass_avail;
    logic bypass_take;
    logic fifo_alloc;
    logic fifo_free;

    // Next-state values
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W-1:0] ckpt_next;
    logic [CNT_W-1:0] since_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W:0]   restore_sum;

    // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Decode alloc/free acceptance and drive the combinational outputs
    always_comb begin
        empty     = (count == '0);
        free_ok   = free_en && (free_pd != '0) && (count < DEPTH_C);
        free_drop = free_en && (free_pd != '0) && (count >= DEPTH_C);
`ifdef FREE_LIST_BYPASS_EN
        bypass_avail = empty && free_ok;
`else
        bypass_avail = 1'b0;
`endif
        alloc_gnt   = alloc_req && !mispredict && (!empty || bypass_avail);
        bypass_take = bypass_avail && alloc_gnt;
        pd_new      = bypass_avail ? free_pd : mem[head];
        // A bypassed tag never enters the FIFO, so neither pointer moves
        fifo_alloc  = alloc_gnt && !bypass_take;
        fifo_free   = free_ok && !bypass_take;
    end

    // Compute pointer, count and checkpoint updates for this cycle
    always_comb begin
        head_next   = head;
        tail_next   = tail;
        ckpt_next   = ckpt_head;
        since_next  = alloc_since_ckpt;
        count_next  = count;
        restore_sum = {1'b0, count} + {1'b0, alloc_since_ckpt}
                    + (CNT_W + 1)'(fifo_free);

        if (fifo_free) begin
            tail_next = next_ptr(tail);
        end

        if (mispredict) begin
            // Rewind head; tags handed out since the checkpoint become free again
            head_next  = ckpt_head;
            since_next = '0;
            count_next = (restore_sum > DEPTH_W) ? DEPTH_C : restore_sum[CNT_W-1:0];
        end else begin
            if (fifo_alloc) begin
                head_next = next_ptr(head);
            end
            case ({fifo_alloc, fifo_free})
                2'b10:   count_next = count - 1'b1;
                2'b01:   count_next = count + 1'b1;
                default: count_next = count;
            endcase
            if (ckpt_take) begin
                ckpt_next  = head_next;
                since_next = '0;
            end else if (fifo_alloc && (alloc_since_ckpt != DEPTH_C)) begin
                // Bypassed tags are not counted: head never passed them
                since_next = alloc_since_ckpt + 1'b1;
            end
        end
    end

    // Register pointers, count, checkpoint and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            head             <= '0;
            tail             <= '0;
            ckpt_head        <= '0;
            alloc_since_ckpt <= '0;
            count            <= DEPTH_C;
            overflow_err     <= 1'b0;
        end else begin
            head             <= head_next;
            tail             <= tail_next;
            ckpt_head        <= ckpt_next;
            alloc_since_ckpt <= since_next;
            count            <= count_next;
            overflow_err     <= overflow_err | free_drop;
        end
    end

    // Tag storage: loaded with the unmapped tags at reset, written at the tail
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= TAG_W'(NUM_ARCH + i);
            end
        end else if (fifo_free) begin
            mem[tail] <= free_pd;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: vector table plus directed sequences for free_list.
// Each driven vector carries its expected outputs into a scoreboard queue;
// the monitor pops and compares on the falling edge of the same cycle.
module tb_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [6:0] pd_new;
    logic       empty;
    logic       free_en;
    logic [6:0] free_pd;
    logic       ckpt_take;
    logic       mispredict;
    logic [6:0] count;
    logic       overflow_err;

    always #5 clk = ~clk;

    free_list #(.NUM_ARCH(32), .NUM_PHYS(128)) dut (
        .clk(clk),
        .reset(reset),
        .alloc_req(alloc_req),
        .alloc_gnt(alloc_gnt),
        .pd_new(pd_new),
        .empty(empty),
        .free_en(free_en),
        .free_pd(free_pd),
        .ckpt_take(ckpt_take),
        .mispredict(mispredict),
        .count(count),
        .overflow_err(overflow_err)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       areq;
        logic       fen;
        logic [6:0] fpd;
        logic       ck;
        logic       mp;
        logic       gnt;
        logic       chk_pd;
        logic [6:0] pd;
        logic [6:0] cnt;
        logic       emp;
        logic       ovf;
    } vec_t;

    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(string n, bit rst, bit areq, bit fen, int fpd,
                                bit ck, bit mp, bit gnt, bit chk_pd, int pd,
                                int cnt, bit emp, bit ovf);
        vec_t v;
        v.name = n;      v.rst = rst;     v.areq = areq;  v.fen = fen;
        v.fpd = 7'(fpd); v.ck = ck;       v.mp = mp;      v.gnt = gnt;
        v.chk_pd = chk_pd; v.pd = 7'(pd); v.cnt = 7'(cnt);
        v.emp = emp;     v.ovf = ovf;
        return v;
    endfunction

    task automatic check(string nm, string fld, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare the outputs of the vector driven this cycle
    always @(negedge clk) begin
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, "alloc_gnt", int'(alloc_gnt), int'(e.gnt));
            if (e.chk_pd) check(e.name, "pd_new", int'(pd_new), int'(e.pd));
            check(e.name, "count", int'(count), int'(e.cnt));
            check(e.name, "empty", int'(empty), int'(e.emp));
            check(e.name, "overflow_err", int'(overflow_err), int'(e.ovf));
        end
    end

    task automatic drive(vec_t v);
        reset      = v.rst;
        alloc_req  = v.areq;
        free_en    = v.fen;
        free_pd    = v.fpd;
        ckpt_take  = v.ck;
        mispredict = v.mp;
        sb.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; alloc_req = 1'b0; free_en = 1'b0; free_pd = '0;
        ckpt_take = 1'b0; mispredict = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // n back-to-back granted allocs starting from a known head tag and count
    task automatic alloc_run(string tag, int n, int pd0, int cnt0, bit ovf);
        for (int i = 0; i < n; i++) begin
            drive(mk($sformatf("%s%0d", tag, i), 1, 1, 0, 0, 0, 0,
                     1, 1, pd0 + i, cnt0 - i, 0, ovf));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[16];
        //             name          rst areq fen fpd ck mp   gnt chk pd  cnt emp ovf
        tbl[0]  = mk("rst_state",    1, 0, 0,  0, 0, 0,   0, 1, 32, 96, 0, 0);
        tbl[1]  = mk("alloc_a",      1, 1, 0,  0, 0, 0,   1, 1, 32, 96, 0, 0);
        tbl[2]  = mk("alloc_b",      1, 1, 0,  0, 0, 0,   1, 1, 33, 95, 0, 0);
        tbl[3]  = mk("alloc_c",      1, 1, 0,  0, 0, 0,   1, 1, 34, 94, 0, 0);
        tbl[4]  = mk("idle_a",       1, 0, 0,  0, 0, 0,   0, 1, 35, 93, 0, 0);
        tbl[5]  = mk("free_zero",    1, 0, 1,  0, 0, 0,   0, 1, 35, 93, 0, 0);
        tbl[6]  = mk("after_zero",   1, 0, 0,  0, 0, 0,   0, 1, 35, 93, 0, 0);
        tbl[7]  = mk("alloc_free",   1, 1, 1, 50, 0, 0,   1, 1, 35, 93, 0, 0);
        tbl[8]  = mk("after_af",     1, 0, 0,  0, 0, 0,   0, 1, 36, 93, 0, 0);
        tbl[9]  = mk("ckpt",         1, 0, 0,  0, 1, 0,   0, 1, 36, 93, 0, 0);
        tbl[10] = mk("spec_a",       1, 1, 0,  0, 0, 0,   1, 1, 36, 93, 0, 0);
        tbl[11] = mk("spec_b",       1, 1, 0,  0, 0, 0,   1, 1, 37, 92, 0, 0);
        tbl[12] = mk("mp_ck",        1, 1, 0,  0, 1, 1,   0, 1, 38, 91, 0, 0);
        tbl[13] = mk("post_mp",      1, 1, 0,  0, 0, 0,   1, 1, 36, 93, 0, 0);
        tbl[14] = mk("mp2",          1, 0, 0,  0, 0, 1,   0, 1, 37, 92, 0, 0);
        tbl[15] = mk("post_mp2",     1, 0, 0,  0, 0, 0,   0, 1, 36, 93, 0, 0);

        do_reset();
        do_reset();
        for (int i = 0; i < 16; i++) drive(tbl[i]);

        // Drain to empty, then refill one tag across the head wrap
        do_reset();
        alloc_run("drain", 96, 32, 96, 0);
        drive(mk("alloc_at_empty", 1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0));
        drive(mk("free40_empty",   1, 0, 1, 40, 0, 0, 0, 0,  0, 0, 1, 0));
        drive(mk("alloc_wrapped",  1, 1, 0,  0, 0, 0, 1, 1, 40, 1, 0, 0));
        drive(mk("empty_again",    1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0));

        // Checkpoint at head=10, speculate 4 tags, mispredict with a free
        do_reset();
        alloc_run("pre", 10, 32, 96, 0);
        drive(mk("ckpt10",         1, 0, 0,  0, 1, 0, 0, 1, 42, 86, 0, 0));
        alloc_run("spec", 4, 42, 86, 0);
        drive(mk("mp_free7",       1, 1, 1,  7, 0, 1, 0, 1, 46, 82, 0, 0));
        drive(mk("after_restore",  1, 1, 0,  0, 0, 0, 1, 1, 42, 87, 0, 0));

        // Overflow at full is sticky; a zero tag is ignored
        do_reset();
        drive(mk("free_full",      1, 0, 1, 50, 0, 0, 0, 1, 32, 96, 0, 0));
        drive(mk("ovf_set",        1, 0, 0,  0, 0, 0, 0, 1, 32, 96, 0, 1));
        drive(mk("alloc_ovf",      1, 1, 0,  0, 0, 0, 1, 1, 32, 96, 0, 1));
        drive(mk("free0_95",       1, 0, 1,  0, 0, 0, 0, 1, 33, 95, 0, 1));
        drive(mk("ovf_sticky",     1, 0, 0,  0, 0, 0, 0, 1, 33, 95, 0, 1));

        // Reset in the middle of a run clears everything, including the flag
        do_reset();
        drive(mk("set_ovf",        1, 0, 1, 50, 0, 0, 0, 1, 32, 96, 0, 0));
        alloc_run("mid", 36, 32, 96, 1);
        drive(mk("rst_mid",        0, 1, 0,  0, 0, 0, 1, 1, 68, 60, 0, 1));
        drive(mk("post_rst",       1, 0, 0,  0, 0, 0, 0, 1, 32, 96, 0, 0));

        // Alloc and free together at count==0
        do_reset();
        alloc_run("drn", 96, 32, 96, 0);
`ifdef FREE_LIST_BYPASS_EN
        drive(mk("bypass77",       1, 1, 1, 77, 0, 0, 1, 1, 77, 0, 1, 0));
        drive(mk("byp_still_0",    1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0));
        drive(mk("free60_empty",   1, 0, 1, 60, 0, 0, 0, 1, 60, 0, 1, 0));
        drive(mk("alloc60",        1, 1, 0,  0, 0, 0, 1, 1, 60, 1, 0, 0));
`else
        drive(mk("nobyp77",        1, 1, 1, 77, 0, 0, 0, 0,  0, 0, 1, 0));
        drive(mk("landed77",       1, 0, 0,  0, 0, 0, 0, 1, 77, 1, 0, 0));
        drive(mk("alloc77",        1, 1, 0,  0, 0, 0, 1, 1, 77, 1, 0, 0));
`endif

        @(negedge clk);
        check("end", "scoreboard_left", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
